// File: rtl/r_phase_pkg.sv
// Shared types and defaults for the kernel-row phase counter and the sibling L/J counters.
package r_phase_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int R_DEF_TERM = 5;

    // Layer 17 suppresses l_zero starts in modes 3 and 4.
    localparam logic [7:0] L17_SKIP_MASK = 8'b0001_1000;

endpackage

// File: rtl/r_phase_counter_if.sv
// Boundary-event / phase-status bundle of the R phase counter; ovf_clr/ovf exist only with R_PHASE_OVF_EN.
interface r_phase_counter_if #(
    parameter int CNT_W  = 3,
    parameter int MODE_W = 3
);
    logic [MODE_W-1:0] u;
    logic              l_zero;
    logic              j_zero;
    logic              k_zero;
    logic [CNT_W-1:0]  term;
    logic              stall;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              r_zero;
`ifdef R_PHASE_OVF_EN
    logic              ovf_clr;
    logic              ovf;

    modport master (
        output u, l_zero, j_zero, k_zero, term, stall, ovf_clr,
        input  cnt, busy, r_zero, ovf
    );

    modport slave (
        input  u, l_zero, j_zero, k_zero, term, stall, ovf_clr,
        output cnt, busy, r_zero, ovf
    );
`else
    modport master (
        output u, l_zero, j_zero, k_zero, term, stall,
        input  cnt, busy, r_zero
    );

    modport slave (
        input  u, l_zero, j_zero, k_zero, term, stall,
        output cnt, busy, r_zero
    );
`endif
endinterface

// File: rtl/r_phase_trig_dec.sv
// Start-trigger decode shared by the R, L and J counters: l_zero is ignored in masked modes.
module r_phase_trig_dec
    import r_phase_pkg::*;
#(
    parameter int MODE_W = 3
) (
    input  logic [MODE_W-1:0]    u,
    input  logic                 l_zero,
    input  logic                 j_zero,
    input  logic                 k_zero,
    input  logic [2**MODE_W-1:0] mask,
    output logic                 trig
);

    assign trig = k_zero | j_zero | (l_zero & ~mask[u]);

endmodule

// File: rtl/r_phase_counter.sv
// Kernel-row phase counter: counts 1..term on a boundary trigger, pulses r_zero on the last count.
// Optional sticky overlap-error flag enabled by defining R_PHASE_OVF_EN.
module r_phase_counter
    import r_phase_pkg::*;
#(
    parameter int                   CNT_W     = 3,
    parameter int                   MODE_W    = 3,
    parameter logic [2**MODE_W-1:0] SKIP_MASK = L17_SKIP_MASK,
    parameter int                   DEF_TERM  = R_DEF_TERM
) (
    input logic              clk,
    input logic              rst,
    r_phase_counter_if.slave bus
);

    localparam logic [CNT_W-1:0] DEF_TERM_C = CNT_W'(DEF_TERM);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] term_q;
    logic [CNT_W-1:0] term_n;
    logic [CNT_W-1:0] term_eff;
    logic             trig;
    logic             start;
    logic             at_term;

    r_phase_trig_dec #(
        .MODE_W (MODE_W)
    ) u_trig_dec (
        .u      (bus.u),
        .l_zero (bus.l_zero),
        .j_zero (bus.j_zero),
        .k_zero (bus.k_zero),
        .mask   (SKIP_MASK),
        .trig   (trig)
    );

    assign term_eff = (bus.term == '0) ? DEF_TERM_C : bus.term;
    assign start    = trig & ~bus.stall;
    assign at_term  = (cnt_q == term_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt_q  <= '0;
            term_q <= DEF_TERM_C;
        end else begin
            state  <= state_n;
            cnt_q  <= cnt_n;
            term_q <= term_n;
        end
    end

    // A trigger landing on the unstalled terminal cycle restarts without an idle gap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt_q;
        term_n  = term_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    cnt_n   = ONE;
                    term_n  = term_eff;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (!at_term) begin
                        cnt_n = cnt_q + ONE;
                    end else if (trig) begin
                        cnt_n  = ONE;
                        term_n = term_eff;
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.cnt    = cnt_q;
    assign bus.busy   = (state == RUN);
    assign bus.r_zero = (state == RUN) & at_term & ~bus.stall;

`ifdef R_PHASE_OVF_EN
    logic ovf_q;
    logic ovf_set;

    // Any trigger the running phase cannot absorb as a restart is an overlap; set beats clear.
    assign ovf_set = (state == RUN) & trig & ~(at_term & ~bus.stall);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
